pipe_stage_reg: RTL and testbench

- Parametrised multi-lane pipeline stage register for the dual-issue pipeline. Replaces the per-boundary hand-written stage registers (ID/EX, EX/MEM, ...).
- Carries a valid bit, a control field and a data payload per lane.
- Distinguishes hold (freeze contents) from flush (insert bubble), and supports per-lane kill for younger-lane squash.
- Provides saturating bubble/hold performance counters.

---
 rtl/pipe_pkg.sv | 53 +++++
 rtl/pipe_lane_reg.sv | 72 +++++++
 rtl/pipe_stage_reg.sv | 76 +++++++
 tb/tb_pipe_stage_reg.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: lane field layout,
// per-boundary default widths and the per-lane update decision.
package pipe_pkg;

    // Control field bit positions (ID/EX layout)
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUOP    = 6;
    localparam int CTRL_ALUOP_W  = 4;

    // Data payload sub-fields (ID/EX layout, 96 bits total)
    localparam int DATA_REG_W       = 5;
    localparam int DATA_RS_OFF      = 0;
    localparam int DATA_RT_OFF      = 5;
    localparam int DATA_RD_OFF      = 10;
    localparam int DATA_SHAMT_OFF   = 15;
    localparam int DATA_IMM_OFF     = 20;
    localparam int DATA_IMM_W       = 16;
    localparam int DATA_PC1_OFF     = 36;
    localparam int DATA_PC1_W       = 12;
    localparam int DATA_RDATA1_OFF  = 48;
    localparam int DATA_RDATA2_OFF  = 72;
    localparam int DATA_RDATA_W     = 24;

    // Default lane widths for each pipeline boundary
    localparam int IDEX_CTRL_W   = 16;
    localparam int IDEX_DATA_W   = 96;
    localparam int EXMEM_CTRL_W  = 8;
    localparam int EXMEM_DATA_W  = 64;
    localparam int MEMWB_CTRL_W  = 4;
    localparam int MEMWB_DATA_W  = 64;

    typedef enum logic [1:0] {
        LANE_LOAD   = 2'd0,
        LANE_HOLD   = 2'd1,
        LANE_BUBBLE = 2'd2
    } lane_op_e;

    // Flush beats hold beats load; kill squashes whichever lane is kept.
    function automatic lane_op_e lane_op(input logic flush, input logic hold,
                                         input logic kill, input logic valid);
        if (flush)
            return LANE_BUBBLE;
        if (hold)
            return kill ? LANE_BUBBLE : LANE_HOLD;
        return (kill || !valid) ? LANE_BUBBLE : LANE_LOAD;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// One lane of a pipeline stage register: valid/ctrl/data with
// load, hold and bubble handling. Exposes next-state valid for counters.
module pipe_lane_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = IDEX_CTRL_W,
    parameter int DATA_W    = IDEX_DATA_W,
    parameter int ZERO_DATA = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic              i_kill,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid_next
);

    lane_op_e          w_op;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_valid_next;
    logic [CTRL_W-1:0] w_ctrl_next;
    logic [DATA_W-1:0] w_data_next;

    assign w_op = lane_op(i_flush, i_hold, i_kill, i_valid);

    always_comb begin
        w_valid_next = r_valid;
        w_ctrl_next  = r_ctrl;
        w_data_next  = r_data;
        case (w_op)
            LANE_LOAD: begin
                w_valid_next = 1'b1;
                w_ctrl_next  = i_ctrl;
                w_data_next  = i_data;
            end
            LANE_BUBBLE: begin
                // ctrl is always cleared so downstream enables need no valid gating
                w_valid_next = 1'b0;
                w_ctrl_next  = '0;
                if (ZERO_DATA != 0)
                    w_data_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_ctrl  <= w_ctrl_next;
            r_data  <= w_data_next;
        end
    end

    assign o_valid      = r_valid;
    assign o_ctrl       = r_ctrl;
    assign o_data       = r_data;
    assign o_valid_next = w_valid_next;

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane pipeline stage register: one pipe_lane_reg per issue lane
// plus saturating bubble and hold performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int CTRL_W    = IDEX_CTRL_W,
    parameter int DATA_W    = IDEX_DATA_W,
    parameter int ZERO_DATA = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*CTRL_W-1:0] in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    hold,
    input  logic                    flush,
    input  logic [LANES-1:0]        kill,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*CTRL_W-1:0] out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        hold_cnt
);

    logic [LANES-1:0] w_valid_next;
    logic             w_bubble_inc;
    logic             w_hold_inc;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_hold_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            pipe_lane_reg #(
                .CTRL_W    (CTRL_W),
                .DATA_W    (DATA_W),
                .ZERO_DATA (ZERO_DATA)
            ) u_lane (
                .clk          (clk),
                .reset        (reset),
                .i_valid      (in_valid[gi]),
                .i_ctrl       (in_ctrl[gi*CTRL_W +: CTRL_W]),
                .i_data       (in_data[gi*DATA_W +: DATA_W]),
                .i_hold       (hold),
                .i_flush      (flush),
                .i_kill       (kill[gi]),
                .o_valid      (out_valid[gi]),
                .o_ctrl       (out_ctrl[gi*CTRL_W +: CTRL_W]),
                .o_data       (out_data[gi*DATA_W +: DATA_W]),
                .o_valid_next (w_valid_next[gi])
            );
        end
    endgenerate

    // Bubble counting looks at the state being written, not the state leaving
    assign w_bubble_inc = (w_valid_next == '0) && (r_bubble_cnt != '1);
    assign w_hold_inc   = hold && !flush && (r_hold_cnt != '1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_bubble_inc)
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (w_hold_inc)
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a zeroing/4-bit-counter instance and a
// data-keeping/16-bit-counter instance share stimulus against a lane model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   in_valid, kill;
    logic [31:0]  in_ctrl;
    logic [191:0] in_data;
    logic         hold, flush;

    logic [1:0]   ov0, ov1;
    logic [31:0]  oc0, oc1;
    logic [191:0] od0, od1;
    logic [3:0]   bc0, hc0;
    logic [15:0]  bc1, hc1;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: index [dut][lane]; dut 0 zeroes data, dut 1 keeps it
    bit          m_v [2][2];
    logic [15:0] m_c [2][2];
    logic [95:0] m_d [2][2];
    int          m_bc [2];
    int          m_hc [2];
    int          m_max [2] = '{15, 65535};
    bit          m_zd [2]  = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    pipe_stage_reg #(.LANES(2), .CTRL_W(16), .DATA_W(96), .ZERO_DATA(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .hold(hold), .flush(flush), .kill(kill), .out_valid(ov0), .out_ctrl(oc0),
        .out_data(od0), .bubble_cnt(bc0), .hold_cnt(hc0));

    pipe_stage_reg #(.LANES(2), .CTRL_W(16), .DATA_W(96), .ZERO_DATA(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .hold(hold), .flush(flush), .kill(kill), .out_valid(ov1), .out_ctrl(oc1),
        .out_data(od1), .bubble_cnt(bc1), .hold_cnt(hc1));

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                for (int l = 0; l < 2; l++) begin
                    m_v[d][l] = 1'b0; m_c[d][l] = '0; m_d[d][l] = '0;
                end
                m_bc[d] = 0; m_hc[d] = 0;
            end else begin
                for (int l = 0; l < 2; l++) begin
                    if (flush || kill[l] || (!hold && !in_valid[l])) begin
                        m_v[d][l] = 1'b0; m_c[d][l] = '0;
                        if (m_zd[d]) m_d[d][l] = '0;
                    end else if (!hold) begin
                        m_v[d][l] = 1'b1;
                        m_c[d][l] = in_ctrl[l*16 +: 16];
                        m_d[d][l] = in_data[l*96 +: 96];
                    end
                end
                if (!m_v[d][0] && !m_v[d][1] && m_bc[d] < m_max[d]) m_bc[d]++;
                if (hold && !flush && m_hc[d] < m_max[d]) m_hc[d]++;
            end
        end
    endfunction

    function automatic logic [1:0]   e_valid(int d); return {m_v[d][1], m_v[d][0]}; endfunction
    function automatic logic [31:0]  e_ctrl(int d);  return {m_c[d][1], m_c[d][0]}; endfunction
    function automatic logic [191:0] e_data(int d);  return {m_d[d][1], m_d[d][0]}; endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b1; hold = 1'b0; flush = 1'b0; kill = 2'b00;
        in_valid = 2'b00; in_ctrl = '0; in_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(); reset = 1'b1;
    endtask

    task automatic load(input logic [1:0] v, input logic [15:0] c0, input logic [15:0] c1,
                        input logic [95:0] d0, input logic [95:0] d1);
        hold = 1'b0; flush = 1'b0; kill = 2'b00;
        in_valid = v; in_ctrl = {c1, c0}; in_data = {d1, d0};
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0; in_valid = 2'b11; in_ctrl = 32'hFFFF_FFFF; in_data = {6{32'hDEAD_BEEF}};
        hold = 1'b0; kill = 2'b00;
        tick(); tick();
        cmp_cnt++;
        if ({ov0, oc0, od0, bc0, hc0} !== '0) begin
            err_cnt++; $display("FAIL reset_dut0: got v=%b c=%h bc=%0d hc=%0d want all 0", ov0, oc0, bc0, hc0);
        end
        cmp_cnt++;
        if ({ov1, oc1, od1, bc1, hc1} !== '0) begin
            err_cnt++; $display("FAIL reset_dut1: got v=%b c=%h bc=%0d hc=%0d want all 0", ov1, oc1, bc1, hc1);
        end
        reset = 1'b1;
        tick();
        cmp_cnt++;
        if (ov0 !== 2'b11 || oc0 !== 32'hFFFF_FFFF || od0 !== {6{32'hDEAD_BEEF}}) begin
            err_cnt++; $display("FAIL reset_release_load: got v=%b c=%h want v=11 c=ffffffff", ov0, oc0);
        end
        $display("test_reset: outputs cleared under reset, first edge after release loaded");
    endtask

    task automatic test_load();
        set_idle(); do_reset();
        load(2'b11, 16'h00A5, 16'h0F0F, 96'h1, 96'h2);
        cmp_cnt++;
        if (ov0 !== 2'b11 || oc0 !== 32'h0F0F_00A5 || od0 !== {96'h2, 96'h1}) begin
            err_cnt++; $display("FAIL load_fields: got v=%b c=%h d=%h want v=11 c=0f0f00a5", ov0, oc0, od0);
        end
        cmp_cnt++;
        if (od0[96+DATA_RS_OFF +: DATA_REG_W] !== 5'd2 || od0[96+DATA_RT_OFF +: DATA_REG_W] !== 5'd0) begin
            err_cnt++; $display("FAIL load_rs_rt: got rs=%0d rt=%0d want rs=2 rt=0",
                                od0[96+DATA_RS_OFF +: DATA_REG_W], od0[96+DATA_RT_OFF +: DATA_REG_W]);
        end
        $display("test_load: lane0 c=%h lane1 c=%h", oc0[15:0], oc0[31:16]);
    endtask

    task automatic test_hold_kill();
        logic [1:0] want_v;
        set_idle(); do_reset();
        load(2'b11, 16'h1234, 16'h5678, 96'hAAA, 96'hBBB);
        in_valid = 2'b00; in_ctrl = 32'hFFFF_FFFF; in_data = '1; hold = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            kill = (cyc == 2) ? 2'b10 : 2'b00;
            tick();
            want_v = (cyc >= 2) ? 2'b01 : 2'b11;
            cmp_cnt++;
            if (ov0 !== want_v || oc0[15:0] !== 16'h1234 || od0[95:0] !== 96'hAAA) begin
                err_cnt++; $display("FAIL hold_kill_c%0d: got v=%b c0=%h want v=%b c0=1234", cyc, ov0, oc0[15:0], want_v);
            end
            cmp_cnt++;
            if (cyc >= 2 && (oc0[31:16] !== 16'h0 || od0[191:96] !== 96'h0 || od1[191:96] !== 96'hBBB)) begin
                err_cnt++; $display("FAIL hold_kill_lane1_c%0d: got c1=%h d0=%h d1=%h want 0/0/bbb",
                                    cyc, oc0[31:16], od0[191:96], od1[191:96]);
            end
        end
        cmp_cnt++;
        if (hc0 !== 4'd3 || bc0 !== 4'd0 || hc1 !== 16'd3) begin
            err_cnt++; $display("FAIL hold_kill_cnt: got hc=%0d bc=%0d want hc=3 bc=0", hc0, bc0);
        end
        hold = 1'b0; kill = 2'b00;
        $display("test_hold_kill: lane1 squashed mid-hold, hold_cnt=%0d", hc0);
    endtask

    task automatic test_flush();
        int bc_prev, hc_prev;
        set_idle(); do_reset();
        load(2'b11, 16'hC0DE, 16'hBEEF, 96'h111, 96'h222);
        bc_prev = int'(bc1); hc_prev = int'(hc1);
        flush = 1'b1; hold = 1'b1; kill = 2'b01; in_valid = 2'b11;
        tick();
        cmp_cnt++;
        if (ov0 !== 2'b00 || oc0 !== '0 || od0 !== '0) begin
            err_cnt++; $display("FAIL flush_zero: got v=%b c=%h d=%h want all 0", ov0, oc0, od0);
        end
        cmp_cnt++;
        if (ov1 !== 2'b00 || oc1 !== '0 || od1 !== {96'h222, 96'h111}) begin
            err_cnt++; $display("FAIL flush_keepdata: got v=%b c=%h d=%h want d=222/111", ov1, oc1, od1);
        end
        cmp_cnt++;
        if (int'(bc1) !== bc_prev + 1 || int'(hc1) !== hc_prev) begin
            err_cnt++; $display("FAIL flush_cnt: got bc=%0d hc=%0d want bc=%0d hc=%0d", bc1, hc1, bc_prev + 1, hc_prev);
        end
        flush = 1'b0; hold = 1'b0; kill = 2'b00;
        $display("test_flush: flush overrode hold and kill, bubble_cnt=%0d", bc1);
    endtask

    task automatic test_partial();
        int bc_prev;
        set_idle(); do_reset();
        load(2'b11, 16'h1111, 16'h2222, 96'h33, 96'h44);
        bc_prev = int'(bc0);
        load(2'b10, 16'h5555, 16'h6666, 96'h77, 96'h88);
        cmp_cnt++;
        if (ov0 !== 2'b10 || oc0 !== 32'h6666_0000 || od0 !== {96'h88, 96'h0}) begin
            err_cnt++; $display("FAIL partial_lanes: got v=%b c=%h want v=10 c=66660000", ov0, oc0);
        end
        cmp_cnt++;
        if (od1[95:0] !== 96'h33 || int'(bc0) !== bc_prev) begin
            err_cnt++; $display("FAIL partial_keep_bc: got d0=%h bc=%0d want d0=33 bc=%0d", od1[95:0], bc0, bc_prev);
        end
        $display("test_partial: in_valid=10 -> out_valid=%b", ov0);
    endtask

    task automatic test_saturation();
        int want;
        set_idle(); do_reset();
        flush = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            want = (i > 15) ? 15 : i;
            cmp_cnt++;
            if (int'(bc0) !== want || int'(bc1) !== i) begin
                err_cnt++; $display("FAIL sat_c%0d: got bc0=%0d bc1=%0d want %0d/%0d", i, bc0, bc1, want, i);
            end
        end
        flush = 1'b0;
        do_reset();
        cmp_cnt++;
        if (bc0 !== 4'd0) begin
            err_cnt++; $display("FAIL sat_reset: got bc0=%0d want 0", bc0);
        end
        $display("test_saturation: bubble_cnt pinned at 15, cleared by reset");
    endtask

    task automatic test_random();
        set_idle(); do_reset();
        for (int t = 0; t < 300; t++) begin
            reset    = ($urandom_range(0, 49) != 0);
            hold     = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            kill     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            in_valid = 2'($urandom_range(0, 3));
            in_ctrl  = $urandom;
            in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
            cmp_cnt++;
            if ({ov0, oc0, od0, bc0, hc0} !== {e_valid(0), e_ctrl(0), e_data(0), 4'(m_bc[0]), 4'(m_hc[0])}) begin
                err_cnt++; $display("FAIL rand_dut0_t%0d: got v=%b c=%h bc=%0d hc=%0d want v=%b c=%h bc=%0d hc=%0d",
                                    t, ov0, oc0, bc0, hc0, e_valid(0), e_ctrl(0), m_bc[0], m_hc[0]);
            end
            cmp_cnt++;
            if ({ov1, oc1, od1, bc1, hc1} !== {e_valid(1), e_ctrl(1), e_data(1), 16'(m_bc[1]), 16'(m_hc[1])}) begin
                err_cnt++; $display("FAIL rand_dut1_t%0d: got v=%b c=%h bc=%0d hc=%0d want v=%b c=%h bc=%0d hc=%0d",
                                    t, ov1, oc1, bc1, hc1, e_valid(1), e_ctrl(1), m_bc[1], m_hc[1]);
            end
            $display("txn %0d: rst=%b fl=%b ho=%b kill=%b vin=%b -> v=%b bc=%0d hc=%0d",
                     t, reset, flush, hold, kill, in_valid, ov0, bc1, hc1);
        end
        reset = 1'b1;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load();
        test_hold_kill();
        test_flush();
        test_partial();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
